// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM demultiplexer.
// Optional error counter width is used only when TDM_DEMUX_ERRCNT_EN is defined.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int ERRCNT_W = 8;
  localparam int MAX_CH   = 16;

  // Strobe for the widest legal frame; callers truncate to their channel count.
  function automatic logic [MAX_CH-1:0] onehot(input logic [3:0] slot);
    logic [MAX_CH-1:0] v;
    v = '0;
    v[slot] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// Slot-multiplexed link plus demultiplexed channel outputs.
// err_count is present only when TDM_DEMUX_ERRCNT_EN is defined.
interface tdm_demux_if
  import tdm_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 1
);

  logic [WIDTH-1:0]          din;
  logic                      din_valid;
  logic                      frame_sync;
  logic [CHANNELS*WIDTH-1:0] dout;
  logic [CHANNELS-1:0]       ch_strobe;
  logic                      frame_done;
  logic                      locked;
  logic                      sync_err;
`ifdef TDM_DEMUX_ERRCNT_EN
  logic [ERRCNT_W-1:0]       err_count;
`endif

  modport master (
    output din, din_valid, frame_sync,
    input  dout, ch_strobe, frame_done, locked, sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
    , input err_count
`endif
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output dout, ch_strobe, frame_done, locked, sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
    , output err_count
`endif
  );

endinterface

// File: rtl/tdm_slot_ctr.sv
// Slot counter: increments on enable, wraps after CHANNELS-1, load forces slot 1.
module tdm_slot_ctr #(
  parameter int CHANNELS = 8,
  parameter int SLOT_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load1,
  output logic [SLOT_W-1:0] slot,
  output logic              is_last
);

  assign is_last = (slot == SLOT_W'(CHANNELS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (load1) begin
      slot <= SLOT_W'(1);
    end else if (en) begin
      slot <= is_last ? '0 : slot + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// 1:N TDM demultiplexer with frame-sync alignment and lock tracking.
// Define TDM_DEMUX_ERRCNT_EN to add the saturating err_count output.
//
// state | meaning
// HUNT  | unaligned; samples dropped until frame_sync arrives
// RUN   | aligned; samples routed to channel = slot
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 1,
  parameter int SLOT_W   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux_if.slave   bus
);

  state_t                    state_q, state_d;
  logic [SLOT_W-1:0]         slot;
  logic                      is_last;
  logic                      slot_zero;
  logic                      ctr_en, ctr_load;
  logic                      lock_set, lock_clr;
  logic [CHANNELS-1:0]       strobe_d;
  logic                      frame_done_d, sync_err_d;

  logic [CHANNELS*WIDTH-1:0] dout_q;
  logic [CHANNELS-1:0]       strobe_q;
  logic                      frame_done_q, sync_err_q, locked_q;

  assign slot_zero = (slot == '0);

  tdm_slot_ctr #(
    .CHANNELS (CHANNELS),
    .SLOT_W   (SLOT_W)
  ) u_slot_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (ctr_en),
    .load1   (ctr_load),
    .slot    (slot),
    .is_last (is_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HUNT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.din_valid) begin
      case (state_q)
        HUNT:    if (bus.frame_sync) state_d = RUN;
        RUN:     if (!bus.frame_sync && slot_zero) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    strobe_d     = '0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    lock_set     = 1'b0;
    lock_clr     = 1'b0;
    ctr_en       = 1'b0;
    ctr_load     = 1'b0;
    if (bus.din_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.frame_sync) begin
            strobe_d = CHANNELS'(onehot(4'd0));
            ctr_load = 1'b1;
          end
        end
        RUN: begin
          if (bus.frame_sync == slot_zero) begin
            strobe_d     = CHANNELS'(onehot(4'(slot)));
            ctr_en       = 1'b1;
            frame_done_d = is_last;
            lock_set     = is_last;
          end else if (bus.frame_sync) begin
            // Early sync restarts the frame; the sample becomes channel 0.
            strobe_d   = CHANNELS'(onehot(4'd0));
            ctr_load   = 1'b1;
            sync_err_d = 1'b1;
            lock_clr   = 1'b1;
          end else begin
            sync_err_d = 1'b1;
            lock_clr   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q     <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      strobe_q     <= strobe_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      if (lock_clr)      locked_q <= 1'b0;
      else if (lock_set) locked_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (strobe_d[c]) dout_q[c*WIDTH +: WIDTH] <= bus.din;
      end
    end
  end

`ifdef TDM_DEMUX_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (sync_err_d && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
    end
  end

  assign bus.err_count = err_cnt_q;
`endif

  assign bus.dout       = dout_q;
  assign bus.ch_strobe  = strobe_q;
  assign bus.frame_done = frame_done_q;
  assign bus.locked     = locked_q;
  assign bus.sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux with CHANNELS=4, WIDTH=4.
// Build with TDM_DEMUX_ERRCNT_EN defined to also exercise err_count saturation.
module tb_tdm_demux;
  import tdm_pkg::*;

  localparam int CH = 4;
  localparam int W  = 4;

  logic clk;
  logic rst_n;

  tdm_demux_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  tdm_demux #(.CHANNELS(CH), .WIDTH(W), .SLOT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CH*W-1:0] dout;
    logic [CH-1:0]   strobe;
    logic            fd;
    logic            locked;
    logic            serr;
    logic [7:0]      err;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  // Reference model
  logic       m_run;
  int         m_slot;
  logic [W-1:0] m_dout[CH];
  logic       m_locked;
  int         m_err;

  task automatic model_reset();
    m_run    = 1'b0;
    m_slot   = 0;
    m_locked = 1'b0;
    m_err    = 0;
    for (int i = 0; i < CH; i++) m_dout[i] = '0;
  endtask

  task automatic drive(input logic v, input logic fs, input logic [W-1:0] d, input string tag);
    exp_t e;
    exp_t got;
    bus.din        = d;
    bus.din_valid  = v;
    bus.frame_sync = fs;
    e.strobe = '0;
    e.fd     = 1'b0;
    e.serr   = 1'b0;
    if (v) begin
      if (!m_run) begin
        if (fs) begin
          m_dout[0] = d;
          e.strobe  = 4'b0001;
          m_slot    = 1;
          m_run     = 1'b1;
        end
      end else if ((fs && m_slot == 0) || (!fs && m_slot != 0)) begin
        m_dout[m_slot] = d;
        e.strobe = 4'(1 << m_slot);
        if (m_slot == CH - 1) begin
          e.fd     = 1'b1;
          m_locked = 1'b1;
          m_slot   = 0;
        end else begin
          m_slot = m_slot + 1;
        end
      end else if (fs) begin
        e.serr    = 1'b1;
        m_locked  = 1'b0;
        m_dout[0] = d;
        e.strobe  = 4'b0001;
        m_slot    = 1;
      end else begin
        e.serr   = 1'b1;
        m_locked = 1'b0;
        m_run    = 1'b0;
      end
    end
    if (e.serr && m_err < 255) m_err = m_err + 1;
    e.dout   = {m_dout[3], m_dout[2], m_dout[1], m_dout[0]};
    e.locked = m_locked;
    e.err    = 8'(m_err);
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    n_checks++;
    if (bus.dout !== got.dout) begin
      n_fail++;
      $display("FAIL %s dout: got %h expected %h", tag, bus.dout, got.dout);
    end
    n_checks++;
    if (bus.ch_strobe !== got.strobe) begin
      n_fail++;
      $display("FAIL %s ch_strobe: got %b expected %b", tag, bus.ch_strobe, got.strobe);
    end
    n_checks++;
    if (bus.frame_done !== got.fd) begin
      n_fail++;
      $display("FAIL %s frame_done: got %b expected %b", tag, bus.frame_done, got.fd);
    end
    n_checks++;
    if (bus.locked !== got.locked) begin
      n_fail++;
      $display("FAIL %s locked: got %b expected %b", tag, bus.locked, got.locked);
    end
    n_checks++;
    if (bus.sync_err !== got.serr) begin
      n_fail++;
      $display("FAIL %s sync_err: got %b expected %b", tag, bus.sync_err, got.serr);
    end
`ifdef TDM_DEMUX_ERRCNT_EN
    n_checks++;
    if (bus.err_count !== got.err) begin
      n_fail++;
      $display("FAIL %s err_count: got %0d expected %0d", tag, bus.err_count, got.err);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    model_reset();
    #23;
    n_checks++;
    if ({bus.dout, bus.ch_strobe, bus.frame_done, bus.locked, bus.sync_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got dout=%h strobe=%b fd=%b lk=%b se=%b expected all zero",
               bus.dout, bus.ch_strobe, bus.frame_done, bus.locked, bus.sync_err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_full_frame();
    logic [CH-1:0] exp_seq[CH];
    logic [W-1:0]  vals[CH];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    vals    = '{4'hA, 4'hB, 4'hC, 4'hD};
    for (int i = 0; i < CH; i++) begin
      drive(1'b1, (i == 0), vals[i], "full_frame");
      n_checks++;
      if (bus.ch_strobe !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL full_frame_strobe%0d: got %b expected %b", i, bus.ch_strobe, exp_seq[i]);
      end
    end
    n_checks++;
    if (bus.dout !== 16'hDCBA || bus.frame_done !== 1'b1 || bus.locked !== 1'b1) begin
      n_fail++;
      $display("FAIL full_frame_end: got dout=%h fd=%b lk=%b expected dcba 1 1",
               bus.dout, bus.frame_done, bus.locked);
    end
  endtask

  task automatic test_gap();
    drive(1'b1, 1'b1, 4'h1, "gap");
    drive(1'b1, 1'b0, 4'h2, "gap");
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 4'hF, "gap_idle");
    drive(1'b1, 1'b0, 4'h3, "gap");
    n_checks++;
    if (bus.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_early_done: got %b expected 0", bus.frame_done);
    end
    drive(1'b1, 1'b0, 4'h4, "gap");
    n_checks++;
    if (bus.dout !== 16'h4321 || bus.frame_done !== 1'b1 || bus.sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_end: got dout=%h fd=%b se=%b expected 4321 1 0",
               bus.dout, bus.frame_done, bus.sync_err);
    end
  endtask

  task automatic test_early_sync();
    drive(1'b1, 1'b1, 4'h6, "early");
    drive(1'b1, 1'b0, 4'h7, "early");
    drive(1'b1, 1'b1, 4'h5, "early_err");
    n_checks++;
    if (bus.sync_err !== 1'b1 || bus.locked !== 1'b0 || bus.ch_strobe !== 4'b0001 ||
        bus.dout !== 16'h4375) begin
      n_fail++;
      $display("FAIL early_sync: got se=%b lk=%b strobe=%b dout=%h expected 1 0 0001 4375",
               bus.sync_err, bus.locked, bus.ch_strobe, bus.dout);
    end
    drive(1'b1, 1'b0, 4'h8, "early_rec");
    drive(1'b1, 1'b0, 4'h9, "early_rec");
    drive(1'b1, 1'b0, 4'hA, "early_rec");
    n_checks++;
    if (bus.locked !== 1'b1 || bus.dout !== 16'hA985) begin
      n_fail++;
      $display("FAIL early_relock: got lk=%b dout=%h expected 1 a985", bus.locked, bus.dout);
    end
  endtask

  task automatic test_missing_sync();
    drive(1'b1, 1'b0, 4'hB, "missing_err");
    n_checks++;
    if (bus.sync_err !== 1'b1 || bus.ch_strobe !== 4'b0000 || bus.dout !== 16'hA985) begin
      n_fail++;
      $display("FAIL missing_sync: got se=%b strobe=%b dout=%h expected 1 0000 a985",
               bus.sync_err, bus.ch_strobe, bus.dout);
    end
    drive(1'b1, 1'b0, 4'hC, "missing_hunt");
    drive(1'b1, 1'b0, 4'hD, "missing_hunt");
    n_checks++;
    if (bus.ch_strobe !== 4'b0000 || bus.sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL missing_hunt: got strobe=%b se=%b expected 0000 0", bus.ch_strobe, bus.sync_err);
    end
    drive(1'b1, 1'b1, 4'hE, "missing_resync");
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 4'h1, "arst_pre");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({bus.dout, bus.ch_strobe, bus.frame_done, bus.locked, bus.sync_err} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got dout=%h strobe=%b fd=%b lk=%b se=%b expected all zero",
               bus.dout, bus.ch_strobe, bus.frame_done, bus.locked, bus.sync_err);
    end
`ifdef TDM_DEMUX_ERRCNT_EN
    n_checks++;
    if (bus.err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset_errcnt: got %0d expected 0", bus.err_count);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'(i + 2), "arst_hunt");
    drive(1'b1, 1'b1, 4'h9, "arst_sync");
  endtask

`ifdef TDM_DEMUX_ERRCNT_EN
  task automatic test_errcnt();
    for (int i = 0; i < 300; i++) drive(1'b1, 1'b1, 4'(i), "errcnt");
    n_checks++;
    if (bus.err_count !== 8'd255) begin
      n_fail++;
      $display("FAIL errcnt_sat: got %0d expected 255", bus.err_count);
    end
    drive(1'b1, 1'b1, 4'h3, "errcnt_hold");
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_gap();
    test_early_sync();
    test_missing_sync();
    test_async_reset();
`ifdef TDM_DEMUX_ERRCNT_EN
    test_errcnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
